// File: rtl/mont_mul_param.sv
// rtl/mont_mul_param.sv - radix-2 bit-serial Montgomery multiplier with start/busy/done handshake
module mont_mul_param #(
   parameter int WIDTH = 2048,
   parameter int LW    = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic [WIDTH-1:0] n_i,
   input  logic [LW-1:0]    n_len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {IDLE, ITER, SUB, DONE} state_t;

   localparam logic [LW-1:0] ONE = LW'(1);

   state_t             state_q;
   logic [WIDTH-1:0]   x_q, y_q, n_q;
   logic [LW-1:0]      len_q, i_q;
   // Accumulator carries two guard bits: S < 2n and S + y + n < 4n
   logic [WIDTH+1:0]   s_q;
   logic [WIDTH+1:0]   t_d, iter_d, sub_d;
   logic               busy_q, done_q, err_q;
   logic [WIDTH-1:0]   result_q;

   // Iteration step (add y if x bit set, make even with n, halve) and final reduction
   always_comb begin
      t_d = s_q;
      if (x_q[i_q]) begin
         t_d = t_d + {2'b00, y_q};
      end
      if (t_d[0]) begin
         t_d = t_d + {2'b00, n_q};
      end
      iter_d = t_d >> 1;
      sub_d  = (s_q >= {2'b00, n_q}) ? (s_q - {2'b00, n_q}) : s_q;
   end

   // Control FSM and datapath registers; enable low freezes everything including a pending done
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         n_q      <= '0;
         len_q    <= '0;
         i_q      <= '0;
         s_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else if (enable_i) begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  x_q    <= x_i;
                  y_q    <= y_i;
                  n_q    <= n_i;
                  len_q  <= n_len_i;
                  i_q    <= '0;
                  s_q    <= '0;
                  busy_q <= 1'b1;
                  err_q  <= 1'b0;
                  // An even modulus has no Montgomery inverse; skip straight to completion
                  state_q <= n_i[0] ? ITER : DONE;
               end
            end
            ITER: begin
               s_q <= iter_d;
               i_q <= i_q + ONE;
               if (i_q == len_q) begin
                  state_q <= SUB;
               end
            end
            SUB: begin
               s_q     <= sub_d;
               state_q <= DONE;
            end
            DONE: begin
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               err_q    <= ~n_q[0];
               result_q <= n_q[0] ? s_q[WIDTH-1:0] : '0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign err_o    = err_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mont_mul_param.sv
// tb/tb_mont_mul_param.sv - directed vector bench for mont_mul_param
module tb_mont_mul_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  x8 = '0, y8 = '0, n8 = '0;
   logic [2:0]  len8 = '0;
   logic        busy8, done8, err8;
   logic [7:0]  res8;

   logic        start64 = 1'b0;
   logic [63:0] x64 = '0, y64 = '0, n64 = '0;
   logic [5:0]  len64 = '0;
   logic        busy64, done64, err64;
   logic [63:0] res64;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mont_mul_param #(.WIDTH(8), .LW(3)) dut8 (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start8),
      .x_i(x8), .y_i(y8), .n_i(n8), .n_len_i(len8),
      .busy_o(busy8), .done_o(done8), .err_o(err8), .result_o(res8)
   );

   mont_mul_param #(.WIDTH(64), .LW(6)) dut64 (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start64),
      .x_i(x64), .y_i(y64), .n_i(n64), .n_len_i(len64),
      .busy_o(busy64), .done_o(done64), .err_o(err64), .result_o(res64)
   );

   typedef struct {
      logic [7:0] n;
      logic [2:0] len;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] res;
      logic       err;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one 8-bit multiply and return cycles from the start edge to the done cycle
   task automatic run8(input logic [7:0] n, input logic [2:0] len,
                       input logic [7:0] x, input logic [7:0] y, output int lat);
      n8 = n; len8 = len; x8 = x; y8 = y;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("busy_after_start", busy8, 1);
      check("err_cleared_on_start", err8, 0);
      lat = 0;
      while (!done8 && lat < 200) begin
         tick();
         lat++;
      end
      check("busy_in_done_cycle", busy8, 0);
   endtask

   task automatic run64(input logic [63:0] n, input logic [63:0] x,
                        input logic [63:0] y, output int lat);
      n64 = n; len64 = 6'd63; x64 = x; y64 = y;
      start64 = 1'b1;
      tick();
      start64 = 1'b0;
      lat = 0;
      while (!done64 && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      vec_t vecs[11];
      int lat;
      logic [191:0] lhs, rhs;
      logic [63:0]  rn, rx, ry;

      // n=13 -> 2^-4 = 9 (mod 13); n=251 -> 2^-8 = 201; n=5 -> 2^-3 = 2
      vecs[0]  = '{8'd13,  3'd3, 8'd5,   8'd7,   8'd3,   1'b0};
      vecs[1]  = '{8'd13,  3'd3, 8'd11,  8'd12,  8'd5,   1'b0};
      vecs[2]  = '{8'd12,  3'd3, 8'd5,   8'd7,   8'd0,   1'b1};
      vecs[3]  = '{8'd13,  3'd3, 8'd5,   8'd7,   8'd3,   1'b0};
      vecs[4]  = '{8'd13,  3'd3, 8'd1,   8'd1,   8'd9,   1'b0};
      vecs[5]  = '{8'd13,  3'd3, 8'd12,  8'd12,  8'd9,   1'b0};
      vecs[6]  = '{8'd13,  3'd3, 8'd7,   8'd3,   8'd7,   1'b0};
      vecs[7]  = '{8'd13,  3'd3, 8'd0,   8'd9,   8'd0,   1'b0};
      vecs[8]  = '{8'd251, 3'd7, 8'd200, 8'd100, 8'd235, 1'b0};
      vecs[9]  = '{8'd251, 3'd7, 8'd250, 8'd250, 8'd201, 1'b0};
      vecs[10] = '{8'd5,   3'd2, 8'd3,   8'd4,   8'd4,   1'b0};

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_busy", busy8, 0);
      check("reset_done", done8, 0);
      check("reset_err", err8, 0);
      check("reset_result", res8, 0);
      check("reset_result64", res64, 0);

      foreach (vecs[k]) begin
         run8(vecs[k].n, vecs[k].len, vecs[k].x, vecs[k].y, lat);
         check($sformatf("v%0d_latency", k), lat,
               vecs[k].err ? 1 : int'(vecs[k].len) + 3);
         check($sformatf("v%0d_result", k), res8, vecs[k].res);
         check($sformatf("v%0d_err", k), err8, vecs[k].err);
         tick();
         check($sformatf("v%0d_done_pulse", k), done8, 0);
         check($sformatf("v%0d_result_held", k), res8, vecs[k].res);
      end

      // Stall three cycles during ITER and pulse start mid-ITER
      n8 = 8'd13; len8 = 3'd3; x8 = 8'd5; y8 = 8'd7;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      tick(); lat++;
      enable = 1'b0;
      repeat (3) begin tick(); lat++; end
      enable = 1'b1;
      tick(); lat++;
      start8 = 1'b1;
      tick(); lat++;
      start8 = 1'b0;
      while (!done8 && lat < 200) begin
         tick();
         lat++;
      end
      check("stall_latency", lat, 9);
      check("stall_result", res8, 3);
      lat = 0;
      repeat (12) begin
         tick();
         if (done8) lat++;
      end
      check("stall_single_done", lat, 0);
      check("stall_idle_busy", busy8, 0);

      // Reset at the second ITER cycle aborts the multiply
      n8 = 8'd13; len8 = 3'd3; x8 = 8'd5; y8 = 8'd7;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_result", res8, 0);
      lat = 0;
      repeat (10) begin
         tick();
         if (done8) lat++;
      end
      check("abort_no_done", lat, 0);
      run8(8'd13, 3'd3, 8'd5, 8'd7, lat);
      check("restart_latency", lat, 6);
      check("restart_result", res8, 3);
      tick();

      // Start held high: back-to-back multiplies every n_len+4 cycles
      n8 = 8'd13; len8 = 3'd3; x8 = 8'd11; y8 = 8'd12;
      start8 = 1'b1;
      tick();
      lat = 0;
      while (!done8 && lat < 200) begin
         tick();
         lat++;
      end
      check("b2b_first_latency", lat, 6);
      check("b2b_first_result", res8, 5);
      lat = 0;
      tick(); lat++;
      check("b2b_busy_reaccept", busy8, 1);
      while (!done8 && lat < 200) begin
         tick();
         lat++;
      end
      start8 = 1'b0;
      check("b2b_period", lat, 7);
      check("b2b_second_result", res8, 5);
      tick();
      tick();
      check("b2b_no_third", busy8, 0);

      // 64-bit operands against an independent congruence check
      for (int v = 0; v < 6; v++) begin
         rn = {1'b1, $urandom(), $urandom_range(32'h7fff_ffff, 0)} | 64'd1;
         rx = {$urandom(), $urandom()} % rn;
         ry = {$urandom(), $urandom()} % rn;
         run64(rn, rx, ry, lat);
         check($sformatf("w64_%0d_latency", v), lat, 66);
         check($sformatf("w64_%0d_err", v), err64, 0);
         check($sformatf("w64_%0d_reduced", v), res64 < rn, 1);
         lhs = ({128'd0, res64} << 64) % {128'd0, rn};
         rhs = ({128'd0, rx} * {128'd0, ry}) % {128'd0, rn};
         check($sformatf("w64_%0d_congruent", v), lhs[63:0], rhs[63:0]);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
